// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: register index and pipeline sequencer states
package cpu_types_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } stall_state_t;

  // Load in EX writes a register the instruction in ID reads; $zero never hazards.
  function automatic logic load_use_hazard(
    input logic     ex_load,
    input regbits_t ex_rt,
    input regbits_t id_rs,
    input regbits_t id_rt,
    input logic     id_uses_rt
  );
    return ex_load && (ex_rt != '0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/stall_ctrl_if.sv
// rtl/stall_ctrl_if.sv - bundle between the stall controller and the datapath stage registers
interface stall_ctrl_if
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
);
  logic             ihit;
  logic             dhit;
  logic             exmem_dmemREN;
  logic             exmem_dmemWEN;
  logic             halt_mem;
  logic             idex_dmemREN;
  regbits_t         idex_rt;
  regbits_t         ifid_rs;
  regbits_t         ifid_rt;
  logic             ifid_uses_rt;
  logic [1:0]       pcsrc;
  logic             pc_EN;
  logic             ifid_EN;
  logic             idex_EN;
  logic             exmem_EN;
  logic             memwb_EN;
  logic             ifid_flush;
  logic             idex_flush;
  logic             halted;
  logic [CNT_W-1:0] cnt_lu;
  logic [CNT_W-1:0] cnt_dwait;
  logic [CNT_W-1:0] cnt_flush;

  modport ctrl (
    input  ihit, dhit, exmem_dmemREN, exmem_dmemWEN, halt_mem, idex_dmemREN,
           idex_rt, ifid_rs, ifid_rt, ifid_uses_rt, pcsrc,
    output pc_EN, ifid_EN, idex_EN, exmem_EN, memwb_EN, ifid_flush, idex_flush,
           halted, cnt_lu, cnt_dwait, cnt_flush
  );

  modport dp (
    output ihit, dhit, exmem_dmemREN, exmem_dmemWEN, halt_mem, idex_dmemREN,
           idex_rt, ifid_rs, ifid_rt, ifid_uses_rt, pcsrc,
    input  pc_EN, ifid_EN, idex_EN, exmem_EN, memwb_EN, ifid_flush, idex_flush,
           halted, cnt_lu, cnt_dwait, cnt_flush
  );
endinterface

// File: rtl/pipe_perf_cnt.sv
// rtl/pipe_perf_cnt.sv - single saturating event counter
module pipe_perf_cnt #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count qualifying cycles, sticking at all-ones instead of wrapping.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - pipeline enable/flush sequencer; PIPE_PERF_EN builds the perf counters
module pipeline_stall_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             exmem_dmemREN,
  input  logic             exmem_dmemWEN,
  input  logic             halt_mem,
  input  logic             idex_dmemREN,
  input  regbits_t         idex_rt,
  input  regbits_t         ifid_rs,
  input  regbits_t         ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic [1:0]       pcsrc,
  output logic             pc_EN,
  output logic             ifid_EN,
  output logic             idex_EN,
  output logic             exmem_EN,
  output logic             memwb_EN,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] cnt_lu,
  output logic [CNT_W-1:0] cnt_dwait,
  output logic [CNT_W-1:0] cnt_flush
);

  stall_state_t state, state_nxt;
  logic dmiss, lu;
  logic win_lu, win_dwait, win_flush;

  assign dmiss = (exmem_dmemREN | exmem_dmemWEN) & ~dhit;
  assign lu    = load_use_hazard(idex_dmemREN, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt);

  // Only the sequencer state is registered; everything else follows the inputs this cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= RUN;
    else       state <= state_nxt;
  end

  // Fixed-priority arbitration: memory wait > halt > branch flush > load-use > fetch miss.
  always_comb begin
    pc_EN      = 1'b1;
    ifid_EN    = 1'b1;
    idex_EN    = 1'b1;
    exmem_EN   = 1'b1;
    memwb_EN   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    halted     = 1'b0;
    win_lu     = 1'b0;
    win_dwait  = 1'b0;
    win_flush  = 1'b0;
    state_nxt  = state;
    case (state)
      RUN, DWAIT: begin
        if (dmiss) begin
          {pc_EN, ifid_EN, idex_EN, exmem_EN, memwb_EN} = 5'b0;
          win_dwait = 1'b1;
          state_nxt = DWAIT;
        end else if (halt_mem) begin
          {pc_EN, ifid_EN, idex_EN, exmem_EN} = 4'b0;
          state_nxt = DRAIN;
        end else begin
          state_nxt = RUN;
          if (pcsrc != 2'b00) begin
            // The redirect must load the PC even if the current fetch has not returned.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            win_flush  = 1'b1;
          end else if (lu) begin
            pc_EN      = 1'b0;
            ifid_EN    = 1'b0;
            idex_flush = 1'b1;
            win_lu     = 1'b1;
          end else if (!ihit) begin
            pc_EN      = 1'b0;
            ifid_flush = 1'b1;
          end
        end
      end
      DRAIN: begin
        {pc_EN, ifid_EN, idex_EN, exmem_EN, memwb_EN} = 5'b0;
        state_nxt = HALT;
      end
      default: begin
        {pc_EN, ifid_EN, idex_EN, exmem_EN, memwb_EN} = 5'b0;
        halted = 1'b1;
      end
    endcase
    // Reset forces quiet outputs at once, whatever the stored state is.
    if (!nRST) begin
      {pc_EN, ifid_EN, idex_EN, exmem_EN, memwb_EN} = 5'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      halted     = 1'b0;
      win_lu     = 1'b0;
      win_dwait  = 1'b0;
      win_flush  = 1'b0;
    end
  end

`ifdef PIPE_PERF_EN
  pipe_perf_cnt #(.W(CNT_W)) u_cnt_lu (
    .CLK(CLK), .nRST(nRST), .inc(win_lu), .count(cnt_lu)
  );
  pipe_perf_cnt #(.W(CNT_W)) u_cnt_dwait (
    .CLK(CLK), .nRST(nRST), .inc(win_dwait), .count(cnt_dwait)
  );
  pipe_perf_cnt #(.W(CNT_W)) u_cnt_flush (
    .CLK(CLK), .nRST(nRST), .inc(win_flush), .count(cnt_flush)
  );
`else
  logic perf_unused;
  assign perf_unused = win_lu ^ win_dwait ^ win_flush;
  assign cnt_lu      = '0;
  assign cnt_dwait   = '0;
  assign cnt_flush   = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - directed self-checking bench for pipeline_stall_ctrl
module tb_pipeline_stall_ctrl;
  import cpu_types_pkg::*;

  localparam int CNT_W = 32;
`ifdef PIPE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc, ifid, idex, exmem, memwb enables, ifid_flush, idex_flush, halted}
  localparam logic [7:0] O_RESET = 8'b00000_000;
  localparam logic [7:0] O_RUN   = 8'b11111_000;
  localparam logic [7:0] O_LU    = 8'b00111_010;
  localparam logic [7:0] O_BR    = 8'b11111_110;
  localparam logic [7:0] O_IMISS = 8'b01111_100;
  localparam logic [7:0] O_FRZ   = 8'b00000_000;
  localparam logic [7:0] O_HALT0 = 8'b00001_000;
  localparam logic [7:0] O_HALTD = 8'b00000_001;

  logic CLK = 1'b0;
  logic nRST;
  logic ihit, dhit, exmem_dmemREN, exmem_dmemWEN, halt_mem, idex_dmemREN, ifid_uses_rt;
  regbits_t idex_rt, ifid_rs, ifid_rt;
  logic [1:0] pcsrc;
  logic pc_EN, ifid_EN, idex_EN, exmem_EN, memwb_EN, ifid_flush, idex_flush, halted;
  logic [CNT_W-1:0] cnt_lu, cnt_dwait, cnt_flush;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  pipeline_stall_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .exmem_dmemREN(exmem_dmemREN), .exmem_dmemWEN(exmem_dmemWEN),
    .halt_mem(halt_mem), .idex_dmemREN(idex_dmemREN), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .pcsrc(pcsrc), .pc_EN(pc_EN), .ifid_EN(ifid_EN), .idex_EN(idex_EN),
    .exmem_EN(exmem_EN), .memwb_EN(memwb_EN), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .halted(halted), .cnt_lu(cnt_lu),
    .cnt_dwait(cnt_dwait), .cnt_flush(cnt_flush)
  );

  function automatic logic [7:0] outs();
    return {pc_EN, ifid_EN, idex_EN, exmem_EN, memwb_EN, ifid_flush, idex_flush, halted};
  endfunction

  function automatic logic [31:0] cexp(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    ihit = 1'b1; dhit = 1'b0; exmem_dmemREN = 1'b0; exmem_dmemWEN = 1'b0;
    halt_mem = 1'b0; idex_dmemREN = 1'b0; ifid_uses_rt = 1'b0;
    idex_rt = '0; ifid_rs = '0; ifid_rt = '0; pcsrc = 2'b00;
  endtask

  // Advance to just after the next rising edge; inputs change here, checks follow #2 later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    idle();
    nRST = 1'b0;
    #12;
    check("reset_outs", 32'(outs()), 32'(O_RESET));
    check("reset_cnt", cnt_lu | cnt_dwait | cnt_flush, 32'd0);
    tick();
    nRST = 1'b1;
    #2 check("run_idle", 32'(outs()), 32'(O_RUN));

    // load-use on rs: one bubble, then the load has left EX
    tick();
    idex_dmemREN = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
    #2 check("lu_rs", 32'(outs()), 32'(O_LU));
    tick();
    idle();
    #2 check("lu_after", 32'(outs()), 32'(O_RUN));
    check("cnt_lu_1", cnt_lu, cexp(1));

    // $zero destination never hazards
    idex_dmemREN = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0;
    #2 check("lu_zero", 32'(outs()), 32'(O_RUN));
    // rt match ignored when ID does not read rt
    idex_rt = 5'd5; ifid_rt = 5'd5; ifid_rs = 5'd3; ifid_uses_rt = 1'b0;
    #1 check("lu_rt_unused", 32'(outs()), 32'(O_RUN));
    ifid_uses_rt = 1'b1;
    #1 check("lu_rt_used", 32'(outs()), 32'(O_LU));
    tick();
    idle();

    // branch beats load-use and a pending fetch
    pcsrc = 2'b01; idex_dmemREN = 1'b1; idex_rt = 5'd7; ifid_rs = 5'd7; ihit = 1'b0;
    #2 check("br_lu", 32'(outs()), 32'(O_BR));
    tick();
    idle();
    #2 check("cnt_flush_1", cnt_flush, cexp(1));
    check("cnt_lu_keep", cnt_lu, cexp(2));

    // instruction fetch miss alone
    ihit = 1'b0;
    #1 check("imiss", 32'(outs()), 32'(O_IMISS));
    tick();
    idle();

    // three-cycle data miss, released in the dhit cycle
    exmem_dmemREN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2 check($sformatf("dmiss_%0d", i), 32'(outs()), 32'(O_FRZ));
      tick();
    end
    dhit = 1'b1;
    #2 check("dmiss_release", 32'(outs()), 32'(O_RUN));
    tick();
    idle();
    #2 check("cnt_dwait_3", cnt_dwait, cexp(3));

    // store miss with a branch in EX: freeze, then branch re-applied on dhit
    exmem_dmemWEN = 1'b1; pcsrc = 2'b10;
    #1 check("dmiss_br", 32'(outs()), 32'(O_FRZ));
    tick();
    dhit = 1'b1;
    #2 check("dhit_br", 32'(outs()), 32'(O_BR));
    tick();
    idle();

    // halt: drain WB, one dead cycle, then halted held
    halt_mem = 1'b1;
    #2 check("halt_c0", 32'(outs()), 32'(O_HALT0));
    tick();
    idle();
    #2 check("halt_c1", 32'(outs()), 32'(O_FRZ));
    tick();
    #2 check("halt_c2", 32'(outs()), 32'(O_HALTD));
    idex_dmemREN = 1'b1; idex_rt = 5'd9; ifid_rs = 5'd9; pcsrc = 2'b01;
    tick();
    tick();
    #2 check("halt_held", 32'(outs()), 32'(O_HALTD));
    check("halt_cnt_frozen", cnt_lu + cnt_flush, cexp(4));
    idle();

    // reset leaves HALT, then async reset while in DWAIT
    nRST = 1'b0;
    #1 check("rst_from_halt", 32'(outs()), 32'(O_RESET));
    tick();
    nRST = 1'b1;
    #2 check("run_after_halt", 32'(outs()), 32'(O_RUN));
    exmem_dmemREN = 1'b1;
    tick();
    #2 check("in_dwait", 32'(outs()), 32'(O_FRZ));
    nRST = 1'b0;
    #1 check("rst_dwait_outs", 32'(outs()), 32'(O_RESET));
    check("rst_dwait_cnt", cnt_lu | cnt_dwait | cnt_flush, 32'd0);
    tick();
    idle();
    nRST = 1'b1;
    #2 check("rst_release", 32'(outs()), 32'(O_RUN));
    ihit = 1'b0;
    #1 check("rst_run_imiss", 32'(outs()), 32'(O_IMISS));
    tick();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Per-core pipeline sequencer for the five-stage MIPS datapath. It owns every pipeline-register enable and flush, plus the PC enable. It arbitrates four things in one fixed priority: memory-wait freezes, halt draining, branch/jump flushes and load-use bubbles. One instance sits in each core's datapath, between the stage registers and the cache `ihit`/`dhit` signals.

## Interface
Parameters:
- CNT_W, 32, width of each performance counter (used only when PIPE_PERF_EN is defined)

Ports:
- CLK  in  1  core clock, rising edge
- nRST  in  1  asynchronous, active-low reset
- ihit  in  1  instruction fetch completed this cycle
- dhit  in  1  data access for the instruction in MEM completed this cycle
- exmem_dmemREN  in  1  instruction in MEM is a load
- exmem_dmemWEN  in  1  instruction in MEM is a store
- halt_mem  in  1  HALT instruction is in MEM
- idex_dmemREN  in  1  instruction in EX is a load
- idex_rt  in  5 (regbits_t)  destination of the load in EX
- ifid_rs  in  5 (regbits_t)  rs of the instruction in ID
- ifid_rt  in  5 (regbits_t)  rt of the instruction in ID
- ifid_uses_rt  in  1  instruction in ID reads rt
- pcsrc  in  2  nonzero means a taken branch/jump resolved in EX
- pc_EN, ifid_EN, idex_EN, exmem_EN, memwb_EN  out  1 each  stage-register enables
- ifid_flush, idex_flush  out  1 each  load a bubble into the stage register
- halted  out  1  core stopped
- cnt_lu, cnt_dwait, cnt_flush  out  CNT_W each  performance counters

## Operation
- FSM: RUN, DWAIT, DRAIN, HALT. The state register is reset asynchronously to RUN. Outputs are combinational from the state and the inputs.
- Definitions:
  - dmiss = (exmem_dmemREN | exmem_dmemWEN) & !dhit
  - lu = idex_dmemREN & idex_rt != 0 & (idex_rt == ifid_rs | (ifid_uses_rt & idex_rt == ifid_rt))
- Default: all enables 1, all flushes 0, halted 0.
- Priority within RUN and DWAIT, highest first:
  1. dmiss: all five enables 0 (full freeze); next state DWAIT.
  2. halt_mem: pc_EN, ifid_EN, idex_EN, exmem_EN = 0; memwb_EN = 1; next state DRAIN.
  3. pcsrc != 0: pc_EN = 1 (even when !ihit), ifid_flush = 1, idex_flush = 1.
  4. lu: pc_EN = 0, ifid_EN = 0, idex_flush = 1. This is exactly one bubble, because the load leaves EX on the next cycle.
  5. !ihit: pc_EN = 0, ifid_flush = 1; later stages advance.
- DWAIT: the freeze holds while dhit = 0. On the dhit cycle the rules above are re-evaluated with dmiss = 0, and the next state is RUN (or DRAIN if halt_mem).
- DRAIN: all enables 0 for one cycle while the HALT instruction's WB completes; next state HALT.
- HALT: all enables 0, halted = 1. Only nRST exits this state.
- Reset mid-operation: outputs immediately take their reset values, regardless of the current state.

## Timing
- Reset values while nRST = 0: all enables 0, all flushes 0, halted 0, counters 0, state RUN.
- All control is zero-latency (same cycle as the inputs); the only registered element is the state.
- Load-use costs exactly 1 cycle.
- A memory wait of N cycles costs N freeze cycles. Release happens in the dhit cycle.
- HALT reaches `halted` 2 cycles after halt_mem is first seen in RUN.
- Simultaneous events:
  - pcsrc != 0 together with lu: the branch wins and no bubble is inserted.
  - dmiss together with pcsrc != 0: freeze. The branch is re-applied on the dhit cycle, because EX is held.

## Configuration
- PIPE_PERF_EN defined: three CNT_W-bit counters, each saturating at all-ones and incremented on the rising clock edge:
  - cnt_lu: cycles where lu wins
  - cnt_dwait: cycles with a dmiss freeze
  - cnt_flush: cycles where the branch flush wins
- Counters freeze in HALT.
- PIPE_PERF_EN undefined: counter ports still exist but are tied to 0, and no counter flops are built.

## Structure
- Add `stall_state_t` (enum RUN, DWAIT, DRAIN, HALT) to cpu_types_pkg. Reuse `regbits_t` from the same package.
- One sub-module, `pipe_perf_cnt`: a single saturating counter, instantiated three times inside the PIPE_PERF_EN guard.
- A `stall_ctrl_if` interface, with modports for the controller and the datapath, accompanies the block.

## Test plan
- Load-use: idex_dmemREN = 1, idex_rt = 5, ifid_rs = 5, ihit = 1. Required: pc_EN = 0, ifid_EN = 0, idex_flush = 1 for exactly 1 cycle; cnt_lu = 1.
- Load-use with idex_rt = 0, or with ifid_uses_rt = 0 and ifid_rt = 5, ifid_rs = 3. Required: no stall.
- Data miss: exmem_dmemREN = 1, dhit = 0 for 3 cycles, then dhit = 1. Required: all enables 0 for 3 cycles; all enables 1 on the 4th; cnt_dwait = 3.
- Branch together with load-use: pcsrc = 1, lu true, ihit = 0. Required: pc_EN = 1, ifid_flush = 1, idex_flush = 1; cnt_flush = 1, cnt_lu = 0.
- Halt: halt_mem = 1. Required: memwb_EN = 1 only in cycle 0; all enables 0 in cycle 1; halted = 1 from cycle 2 and held.
- Async reset: drop nRST while in DWAIT. Required: enables and halted go to 0 immediately; after release the state is RUN and enables go to 1.
